lab3_sys_onchip_memory_pipe: RTL and testbench
==============================================

# lab3_sys_onchip_memory_pipe

Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It is the next-generation program/data memory for the lab Nios II systems and adds configurable width, depth and read latency, explicit `read`/`readdatavalid` pipelining, out-of-range address detection and optional per-byte parity. It sits on the system interconnect in place of the fixed 32-bit, 10000-word, unregistered-output memory.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: data width in bits; must be a multiple of 8.
- `DEPTH`, default 10000: number of words; need not be a power of 2.
- `ADDR_WIDTH`, default 14: word address width; requires 2^ADDR_WIDTH ≥ DEPTH.
- `READ_LATENCY`, default 1: cycles from read acceptance to `readdatavalid`; legal values are 1 and 2.
- `INIT_FILE`, default "": hex init file; an empty string leaves contents undefined.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `reset_req`, in, 1: when high, gates the clock enable, as for `clken` low.
- `clken`, in, 1: global clock enable; when low, all state holds.
- `chipselect`, in, 1: slave select.
- `read`, in, 1: read request.
- `write`, in, 1: write request.
- `address`, in, ADDR_WIDTH: word address.
- `byteenable`, in, DATA_WIDTH/8: byte lane enables.
- `writedata`, in, DATA_WIDTH: write data.
- `readdata`, out, DATA_WIDTH: registered read data.
- `readdatavalid`, out, 1: qualifies `readdata` and `response`.
- `response`, out, 2: 00 OKAY, 10 SLVERR.
- `parity_err`, out, 1: parity mismatch flag, qualified by `readdatavalid`.

## Operation
- Effective enable: `en = clken & ~reset_req`. There is no waitrequest; every request is accepted in the cycle it is presented while `en` is high.
- Write: `chipselect & write & en` and `address < DEPTH` updates only the enabled byte lanes. Writes with `address ≥ DEPTH` are dropped silently.
- Read: `chipselect & read & en` and no write in the same cycle pushes a token (valid, out_of_range) into a READ_LATENCY-deep pipeline.
- If `read` and `write` are both high, the write executes and the read is ignored. No `readdatavalid` is produced for it.
- Out-of-range read: `readdata` = 0, `response` = 10. The RAM is not accessed.
- In-range read: `readdata` is the RAM word, `response` = 00, `parity_err` = 0 (unless parity is enabled and a mismatch is found).
- Unenabled byte lanes keep their old contents. A `byteenable` of all zero with write performs no change.
- Reset: the pipeline is flushed, `readdatavalid` = 0, `readdata` = 0, `response` = 00, `parity_err` = 0. RAM contents are not cleared.
- A reset arriving mid-read discards all in-flight tokens. No `readdatavalid` is produced for them.

## Timing
- Read accepted at cycle N: `readdatavalid` is high at N+READ_LATENCY, counting only `en`-high cycles.
- `en` low freezes the pipeline and all outputs. `readdatavalid` stays at its current value and must not be re-counted by the master while `en` is low.
- Back-to-back reads sustain one per cycle. `readdatavalid` is a one-cycle pulse per accepted read.
- Write at cycle N followed by a read of the same address at N+1 returns the new data (write-first across cycles).
- READ_LATENCY=2 adds an output register after the RAM output register. `readdata` and `response` are always driven from flops.
- Reset takes priority over `en`: it is applied even when `clken` is low.

## Configuration
- Macro: `ONCHIP_MEM_PARITY_EN`.
- Defined:
  - One extra even-parity bit is stored per byte, written on each enabled lane.
  - On an in-range read, parity is recomputed for all lanes.
  - Any mismatch sets `parity_err` = 1 and `response` = 10 in the `readdatavalid` cycle.
  - A test-only input `parity_inject` (1 bit) is present. When high during a write, it inverts the stored parity of lane 0.
- Not defined:
  - No parity storage and no `parity_inject` port.
  - `parity_err` is tied to 0.
  - `response` is 10 only for out-of-range reads.

## Test plan
- Reset, then write 0xDEADBEEF at address 5 with `byteenable` 1111. Read address 5 → at READ_LATENCY cycles later, `readdatavalid` = 1, `readdata` = 0xDEADBEEF, `response` = 00.
- Write 0x11223344 at address 7 with `byteenable` 0101, over a word preloaded with 0xAABBCCDD. Read → `readdata` = 0xAA22CC44.
- Read at address 10000 with DEPTH=10000 → `readdata` = 0, `response` = 10. A write to address 10001 leaves all in-range words unchanged.
- Issue 4 back-to-back reads, with `clken` low for 2 cycles in the middle → exactly 4 `readdatavalid` pulses, in order, delayed by exactly 2 cycles. Run with READ_LATENCY 1 and 2.
- Issue a read, then assert `reset` in the next cycle → no `readdatavalid`, all outputs 0. Memory still holds the previously written data.
- With `ONCHIP_MEM_PARITY_EN` defined, write address 3 with `parity_inject` = 1, then read it → `parity_err` = 1 and `response` = 10. A rewrite of address 3 without inject clears the error on the next read.

Source files
------------

// File: rtl/lab3_sys_onchip_memory_pipe_if.sv
// rtl/lab3_sys_onchip_memory_pipe_if.sv - Avalon-MM slave signal bundle for the on-chip memory
// parity_inject is present only when ONCHIP_MEM_PARITY_EN is defined.
interface lab3_sys_onchip_memory_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  logic                    reset_req;
  logic                    clken;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic [1:0]              response;
  logic                    parity_err;
`ifdef ONCHIP_MEM_PARITY_EN
  logic                    parity_inject;
`endif

  modport master (
    output reset_req, clken, chipselect, read, write, address, byteenable, writedata,
`ifdef ONCHIP_MEM_PARITY_EN
    output parity_inject,
`endif
    input  readdata, readdatavalid, response, parity_err
  );

  modport slave (
    input  reset_req, clken, chipselect, read, write, address, byteenable, writedata,
`ifdef ONCHIP_MEM_PARITY_EN
    input  parity_inject,
`endif
    output readdata, readdatavalid, response, parity_err
  );
endinterface

// File: rtl/lab3_sys_onchip_memory_pipe.sv
// rtl/lab3_sys_onchip_memory_pipe.sv - pipelined single-port on-chip RAM, Avalon-MM slave
// Optional per-byte even parity is enabled with ONCHIP_MEM_PARITY_EN.
module lab3_sys_onchip_memory_pipe #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH        = 10000,
  parameter int    ADDR_WIDTH   = 14,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input logic                          clk,
  input logic                          reset,
  lab3_sys_onchip_memory_pipe_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // Preloading from INIT_FILE is left to the implementation flow.
  localparam bit init_file_unused = (INIT_FILE != "");

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic                  en;
  logic                  in_range;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  rd_perr;
  logic [DATA_WIDTH-1:0] ram_word;
  logic [DATA_WIDTH-1:0] wr_word_d;
`ifdef ONCHIP_MEM_PARITY_EN
  logic [NB-1:0]         par_q [0:DEPTH-1];
  logic [NB-1:0]         ram_par;
  logic [NB-1:0]         calc_par;
  logic [NB-1:0]         wr_par_d;
`endif

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [1:0]            s1_resp_q, s1_resp_d;
  logic                  s1_perr_q, s1_perr_d;

  always_comb begin
    en        = bus.clken & ~bus.reset_req;
    in_range  = {1'b0, bus.address} < DEPTH_LIM;
    wr_acc    = bus.chipselect & bus.write & en & in_range & ~reset;
    rd_acc    = bus.chipselect & bus.read & ~bus.write & en;
    // Out-of-range accesses never touch the array; their data reads as zero.
    ram_word  = in_range ? mem_q[bus.address] : '0;
    wr_word_d = ram_word;
    for (int b = 0; b < NB; b++) begin
      if (bus.byteenable[b]) wr_word_d[b*8 +: 8] = bus.writedata[b*8 +: 8];
    end
`ifdef ONCHIP_MEM_PARITY_EN
    ram_par  = in_range ? par_q[bus.address] : '0;
    wr_par_d = ram_par;
    calc_par = '0;
    for (int b = 0; b < NB; b++) begin
      calc_par[b] = ^ram_word[b*8 +: 8];
      if (bus.byteenable[b]) wr_par_d[b] = ^bus.writedata[b*8 +: 8];
    end
    if (bus.byteenable[0] & bus.parity_inject) wr_par_d[0] = ~wr_par_d[0];
    rd_perr = in_range & (calc_par != ram_par);
`else
    rd_perr = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[bus.address] <= wr_word_d;
`ifdef ONCHIP_MEM_PARITY_EN
      par_q[bus.address] <= wr_par_d;
`endif
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_resp_d  = s1_resp_q;
    s1_perr_d  = s1_perr_q;
    if (en) begin
      s1_valid_d = rd_acc;
      if (rd_acc) begin
        s1_data_d = ram_word;
        s1_perr_d = rd_perr;
        s1_resp_d = (~in_range | rd_perr) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_resp_q  <= RESP_OKAY;
      s1_perr_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_resp_q  <= s1_resp_d;
      s1_perr_q  <= s1_perr_d;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q, s2_valid_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
      logic [1:0]            s2_resp_q, s2_resp_d;
      logic                  s2_perr_q, s2_perr_d;

      always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_resp_d  = s2_resp_q;
        s2_perr_d  = s2_perr_q;
        if (en) begin
          s2_valid_d = s1_valid_q;
          if (s1_valid_q) begin
            s2_data_d = s1_data_q;
            s2_resp_d = s1_resp_q;
            s2_perr_d = s1_perr_q;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
          s2_resp_q  <= RESP_OKAY;
          s2_perr_q  <= 1'b0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
          s2_resp_q  <= s2_resp_d;
          s2_perr_q  <= s2_perr_d;
        end
      end

      assign bus.readdatavalid = s2_valid_q;
      assign bus.readdata      = s2_data_q;
      assign bus.response      = s2_resp_q;
      assign bus.parity_err    = s2_perr_q;
    end else begin : g_lat1
      assign bus.readdatavalid = s1_valid_q;
      assign bus.readdata      = s1_data_q;
      assign bus.response      = s1_resp_q;
      assign bus.parity_err    = s1_perr_q;
    end
  endgenerate
endmodule

// File: tb/tb_lab3_sys_onchip_memory_pipe.sv
// tb/tb_lab3_sys_onchip_memory_pipe.sv - scoreboard bench driving READ_LATENCY 1 and 2 in lockstep
module tb_lab3_sys_onchip_memory_pipe;
  localparam int AW    = 14;
  localparam int DEPTH = 10000;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        perr;
    int          stamp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0, ck = 1'b1, rq = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wd = '0;
`ifdef ONCHIP_MEM_PARITY_EN
  logic        inj = 1'b0;
`endif

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] model [int];
  bit          par_bad [int];
  int          vectors = 0;
  int          miscompares = 0;
  int          encyc = 0;
  int          pool [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 1234, 8191, 9998, 9999};

  always #5 clk = ~clk;

  lab3_sys_onchip_memory_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus1 ();
  lab3_sys_onchip_memory_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus2 ();

  assign bus1.reset_req = rq;  assign bus2.reset_req = rq;
  assign bus1.clken = ck;      assign bus2.clken = ck;
  assign bus1.chipselect = cs; assign bus2.chipselect = cs;
  assign bus1.read = rd;       assign bus2.read = rd;
  assign bus1.write = wr;      assign bus2.write = wr;
  assign bus1.address = addr;  assign bus2.address = addr;
  assign bus1.byteenable = be; assign bus2.byteenable = be;
  assign bus1.writedata = wd;  assign bus2.writedata = wd;
`ifdef ONCHIP_MEM_PARITY_EN
  assign bus1.parity_inject = inj;
  assign bus2.parity_inject = inj;
`endif

  lab3_sys_onchip_memory_pipe #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .READ_LATENCY(1), .INIT_FILE("")) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  lab3_sys_onchip_memory_pipe #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .READ_LATENCY(2), .INIT_FILE("")) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  // Counts the enabled clock edges; a read accepted at count c is due at count c+latency.
  always @(posedge clk) if (!reset && ck && !rq) encyc <= encyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [31:0] data,
                     input logic [1:0] resp, input logic perr);
    exp_t e;
    bit   have;
    if (v !== 1'b1 || ck !== 1'b1 || rq !== 1'b0 || reset !== 1'b0) return;
    have = 1'b0;
    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    if (d == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    if (!have) begin
      vectors++;
      miscompares++;
      $display("FAIL L%0d spurious_valid: got readdatavalid=1 expected none pending", d);
      return;
    end
    cmp($sformatf("L%0d readdata", d), data, e.data);
    cmp($sformatf("L%0d response", d), {30'b0, resp}, {30'b0, e.resp});
    cmp($sformatf("L%0d parity_err", d), {31'b0, perr}, {31'b0, e.perr});
    cmp($sformatf("L%0d valid_cycle", d), encyc, e.stamp);
  endtask

  always @(negedge clk) begin
    mon(1, bus1.readdatavalid, bus1.readdata, bus1.response, bus1.parity_err);
    mon(2, bus2.readdatavalid, bus2.readdata, bus2.response, bus2.parity_err);
  end

  task automatic push_read(input int a, input bit fx, input logic [31:0] fxd);
    exp_t e;
    if (a >= DEPTH) begin
      e.data = 32'h0; e.resp = 2'b10; e.perr = 1'b0;
    end else begin
      e.data = fx ? fxd : model[a];
      e.perr = par_bad.exists(a) ? par_bad[a] : 1'b0;
      e.resp = e.perr ? 2'b10 : 2'b00;
    end
    e.stamp = encyc + 1; q1.push_back(e);
    e.stamp = encyc + 2; q2.push_back(e);
  endtask

  task automatic op(input logic c, input logic r, input logic w, input int a,
                    input logic [3:0] b, input logic [31:0] d, input logic k,
                    input logic q, input logic j, input bit fx, input logic [31:0] fxd);
    logic [31:0] m;
    cs = c; rd = r; wr = w; addr = AW'(a); be = b; wd = d; ck = k; rq = q;
`ifdef ONCHIP_MEM_PARITY_EN
    inj = j;
`endif
    if (c && k && !q) begin
      if (w) begin
        if (a < DEPTH) begin
          m = model.exists(a) ? model[a] : 32'h0;
          for (int i = 0; i < 4; i++) if (b[i]) m[i*8 +: 8] = d[i*8 +: 8];
          model[a] = m;
`ifdef ONCHIP_MEM_PARITY_EN
          if (b[0]) par_bad[a] = j;
`endif
        end
      end else if (r) begin
        push_read(a, fx, fxd);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int a, input logic [3:0] b, input logic [31:0] d);
    op(1, 0, 1, a, b, d, 1, 0, 0, 0, 0);
  endtask
  task automatic do_read(input int a);
    op(1, 1, 0, a, 4'h0, 32'h0, 1, 0, 0, 0, 0);
  endtask
  task automatic do_read_exp(input int a, input logic [31:0] x);
    op(1, 1, 0, a, 4'h0, 32'h0, 1, 0, 0, 1, x);
  endtask
  task automatic idle(input logic k);
    op(0, 0, 0, 0, 4'h0, 32'h0, k, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs();
    cmp("L1 rst readdatavalid", {31'b0, bus1.readdatavalid}, 32'h0);
    cmp("L1 rst readdata", bus1.readdata, 32'h0);
    cmp("L1 rst response", {30'b0, bus1.response}, 32'h0);
    cmp("L1 rst parity_err", {31'b0, bus1.parity_err}, 32'h0);
    cmp("L2 rst readdatavalid", {31'b0, bus2.readdatavalid}, 32'h0);
    cmp("L2 rst readdata", bus2.readdata, 32'h0);
    cmp("L2 rst response", {30'b0, bus2.response}, 32'h0);
    cmp("L2 rst parity_err", {31'b0, bus2.parity_err}, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    idle(1);

    foreach (pool[i]) do_write(pool[i], 4'hF, $urandom);

    do_write(5, 4'hF, 32'hDEADBEEF);
    do_read_exp(5, 32'hDEADBEEF);
    do_write(7, 4'hF, 32'hAABBCCDD);
    do_write(7, 4'b0101, 32'h11223344);
    do_read_exp(7, 32'hAA22CC44);
    do_read(10000);
    do_write(10001, 4'hF, 32'h55555555);
    foreach (pool[i]) do_read(pool[i]);

    do_write(2, 4'hF, 32'h0BADF00D);
    do_read_exp(2, 32'h0BADF00D);

    do_read(0);
    do_read(1);
    op(1, 1, 0, 2, 4'h0, 32'h0, 0, 0, 0, 0, 0);
    idle(0);
    do_read(3);
    do_read(4);

    op(1, 1, 1, 6, 4'hF, 32'hCAFEF00D, 1, 0, 0, 0, 0);
    do_read_exp(6, 32'hCAFEF00D);

    for (int i = 0; i < 400; i++) begin
      int kind;
      int a;
      logic k;
      logic q;
      kind = $urandom_range(0, 9);
      a    = pool[$urandom_range(0, 11)];
      k    = ($urandom_range(0, 7) != 0);
      q    = ($urandom_range(0, 11) == 0);
      case (kind)
        0, 1, 2, 3: op(1, 1, 0, a, 4'h0, 32'h0, k, q, 0, 0, 0);
        4: op(1, 1, 0, DEPTH + $urandom_range(0, (1 << AW) - 1 - DEPTH), 4'h0, 32'h0, k, q, 0, 0, 0);
        5, 6: op(1, 0, 1, a, 4'($urandom_range(0, 15)), $urandom, k, q, 0, 0, 0);
        7: op(1, 0, 1, DEPTH + $urandom_range(0, (1 << AW) - 1 - DEPTH), 4'hF, $urandom, k, q, 0, 0, 0);
        8: op(1, 1, 1, a, 4'($urandom_range(0, 15)), $urandom, k, q, 0, 0, 0);
        default: op(0, 1, 0, a, 4'h0, 32'h0, k, q, 0, 0, 0);
      endcase
    end
    foreach (pool[i]) do_read(pool[i]);

    do_read(5);
    reset = 1'b1;
    q1.delete();
    q2.delete();
    idle(1);
    idle(0);
    check_reset_outputs();
    reset = 1'b0;
    idle(1);
    do_read(5);

`ifdef ONCHIP_MEM_PARITY_EN
    op(1, 0, 1, 3, 4'hF, 32'h12345678, 1, 0, 1, 0, 0);
    do_read_exp(3, 32'h12345678);
    do_write(3, 4'hF, 32'h12345678);
    do_read_exp(3, 32'h12345678);
`endif

    for (int i = 0; i < 20 && (q1.size() > 0 || q2.size() > 0); i++) idle(1);
    if (q1.size() > 0 || q2.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d/%0d reads outstanding expected 0/0", q1.size(), q2.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
